// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator.
// Divides iCLK down to a pixel rate, runs horizontal/vertical position counters
// and registers sync, blanking, position and strobe outputs from their decode.
// Optional feature macro: VGA_TEST_PATTERN_EN adds oRGB, an eight-bar colour
// test pattern.
// Ports:
//   iCLK, iRST        system clock, synchronous active-high reset
//   oHSync, oVSync    sync outputs, active level per HS_POL / VS_POL
//   oVideoOn          presented pixel lies in the visible area
//   oPosX, oPosY      presented pixel column / line
//   oPixelTick        first clock of each presented pixel
//   oLineStart        pixel tick at column 0
//   oFrameStart       pixel tick at column 0, line 0
//   oRGB              test-pattern colour (VGA_TEST_PATTERN_EN only)
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 29,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b0,
    parameter int unsigned CNT_W     = 10
) (
    input  logic             iCLK,
    input  logic             iRST,
    output logic             oHSync,
    output logic             oVSync,
    output logic             oVideoOn,
    output logic [CNT_W-1:0] oPosX,
    output logic [CNT_W-1:0] oPosY,
    output logic             oPixelTick,
    output logic             oLineStart,
    output logic             oFrameStart
`ifdef VGA_TEST_PATTERN_EN
   ,output logic [2:0]       oRGB
`endif
);

    localparam int unsigned H_TOTAL    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_BEG = H_DISPLAY + H_FRONT;
    localparam int unsigned H_SYNC_END = H_DISPLAY + H_FRONT + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_DISPLAY + V_FRONT;
    localparam int unsigned V_SYNC_END = V_DISPLAY + V_FRONT + V_SYNC;
    localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             div_last;

    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_q, video_d;
    logic [CNT_W-1:0] posx_q, posx_d;
    logic [CNT_W-1:0] posy_q, posy_d;
    logic             tick_q, tick_d;
    logic             line_q, line_d;
    logic             frame_q, frame_d;

    // Last clock of the current pixel; always true when CLK_DIV is 1.
    assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

    // Divider and position counters.
    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (div_last) begin
            div_d = '0;
            if (h_q == CNT_W'(H_TOTAL - 1)) begin
                h_d = '0;
                if (v_q == CNT_W'(V_TOTAL - 1)) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + CNT_W'(1);
                end
            end else begin
                h_d = h_q + CNT_W'(1);
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Output decode of the current counter values; registered one clock later.
    always_comb begin
        tick_d  = (div_q == '0);
        line_d  = tick_d && (h_q == '0);
        frame_d = line_d && (v_q == '0);
        video_d = (h_q < CNT_W'(H_DISPLAY)) && (v_q < CNT_W'(V_DISPLAY));
        hsync_d = ((h_q >= CNT_W'(H_SYNC_BEG)) && (h_q < CNT_W'(H_SYNC_END)))
                  ? HS_POL : ~HS_POL;
        vsync_d = ((v_q >= CNT_W'(V_SYNC_BEG)) && (v_q < CNT_W'(V_SYNC_END)))
                  ? VS_POL : ~VS_POL;
        posx_d  = h_q;
        posy_d  = v_q;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            video_q <= 1'b0;
            posx_q  <= '0;
            posy_q  <= '0;
            tick_q  <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            posx_q  <= posx_d;
            posy_q  <= posy_d;
            tick_q  <= tick_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    assign oHSync      = hsync_q;
    assign oVSync      = vsync_q;
    assign oVideoOn    = video_q;
    assign oPosX       = posx_q;
    assign oPosY       = posy_q;
    assign oPixelTick  = tick_q;
    assign oLineStart  = line_q;
    assign oFrameStart = frame_q;

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_DISPLAY / 8;

    logic [CNT_W-1:0] bar_pix_q, bar_pix_d;
    logic [2:0]       bar_idx_q, bar_idx_d;
    logic [2:0]       rgb_q, rgb_d;

    // Bar tracker follows h: pixel-in-bar and bar index, cleared when h wraps.
    // The index saturates at 7; columns past the last bar are blanked anyway.
    always_comb begin
        bar_pix_d = bar_pix_q;
        bar_idx_d = bar_idx_q;
        if (div_last) begin
            if (h_q == CNT_W'(H_TOTAL - 1)) begin
                bar_pix_d = '0;
                bar_idx_d = '0;
            end else if (bar_pix_q == CNT_W'(BAR_W - 1)) begin
                bar_pix_d = '0;
                if (bar_idx_q != 3'd7) begin
                    bar_idx_d = bar_idx_q + 3'd1;
                end
            end else begin
                bar_pix_d = bar_pix_q + CNT_W'(1);
            end
        end
    end

    // Colour decode: white at bar 0 down to black at bar 7, zero while blanked.
    always_comb begin
        rgb_d = video_d ? (3'd7 - bar_idx_q) : 3'd0;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            bar_pix_q <= '0;
            bar_idx_q <= '0;
            rgb_q     <= '0;
        end else begin
            bar_pix_q <= bar_pix_d;
            bar_idx_q <= bar_idx_d;
            rgb_q     <= rgb_d;
        end
    end

    assign oRGB = rgb_q;
`endif

endmodule
